// File: rtl/siso_loop_ctrl.sv
// siso_loop_ctrl
// Sequencing controller for an external serial-in/serial-out shift chain.
// Accepts a parallel word, shifts it LSB-first into the chain, flushes the
// chain with DEPTH zeros and reassembles the emerging bits into rx_data.
//
// Optional feature: define SISO_LOOP_CHECK_EN to build the loopback
// comparator that drives err; without it err is tied low.

module siso_loop_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             sr_din,
    output logic             sr_shift,
    input  logic             sr_q,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             err
);

    localparam int SW = $clog2(WIDTH + DEPTH + 1);

    localparam logic [SW-1:0] S_LAST_SHIFT = SW'(WIDTH - 1);
    localparam logic [SW-1:0] S_LAST_FLUSH = SW'(WIDTH + DEPTH - 1);
    localparam logic [SW-1:0] S_FIRST_CAP  = SW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SW-1:0]    s;
    logic [WIDTH-1:0] tx_word;
    logic [WIDTH-1:0] rx_word;
    logic [WIDTH-1:0] rx_next;
    logic             din_bit;
    logic             capture;
    logic             accept;
    logic             last_flush;

    assign accept     = (state == IDLE) && tx_valid;
    assign last_flush = (state == FLUSH) && (s == S_LAST_FLUSH);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        busy       = 1'b1;
        sr_shift   = 1'b0;
        sr_din     = 1'b0;
        rx_valid   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sr_shift = 1'b1;
                sr_din   = din_bit;
                capture  = (s >= S_FIRST_CAP);
                if (s == S_LAST_SHIFT) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                sr_shift = 1'b1;
                capture  = (s >= S_FIRST_CAP);
                if (s == S_LAST_FLUSH) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rx_valid   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select tx_word[s] without an over-wide dynamic index
    always_comb begin
        din_bit = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s == SW'(i)) begin
                din_bit = tx_word[i];
            end
        end
    end

    // Place sr_q into bit (s - DEPTH) of the word being assembled
    always_comb begin
        rx_next = rx_word;
        if (capture) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s == SW'(i + DEPTH)) begin
                    rx_next[i] = sr_q;
                end
            end
        end
    end

    // Shift counter, latched tx word and rx assembly.
    // The final bit lands on the same edge that enters DONE, so rx_data is
    // loaded from rx_next rather than rx_word to be valid during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s       <= '0;
            tx_word <= '0;
            rx_word <= '0;
            rx_data <= '0;
        end else if (accept) begin
            s       <= '0;
            tx_word <= tx_data;
            rx_word <= '0;
        end else if (sr_shift) begin
            s       <= s + 1'b1;
            rx_word <= rx_next;
            if (last_flush) begin
                rx_data <= rx_next;
            end
        end
    end

`ifdef SISO_LOOP_CHECK_EN
    // Loopback check: flag set entering DONE on mismatch, cleared on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (last_flush) begin
            err <= (rx_next != tx_word);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_loop_ctrl.sv
// Self-checking bench for siso_loop_ctrl (WIDTH=8, DEPTH=4) with a
// behavioural 4-stage SISO chain attached.

module tb_siso_loop_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = WIDTH + DEPTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             sr_din;
    logic             sr_shift;
    logic             sr_q;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SISO_LOOP_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    // External chain; starts with junk and is never reset
    logic [DEPTH-1:0] chain = 4'b1011;
    logic             q_force0;

    assign sr_q = q_force0 ? 1'b0 : chain[DEPTH-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr_shift) chain <= {chain[DEPTH-2:0], sr_din};
    end

    siso_loop_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .sr_din   (sr_din),
        .sr_shift (sr_shift),
        .sr_q     (sr_q),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: k = cycle index after the accept edge (0 = idle)
    int               k;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_rx;
    logic             m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k     = 0;
            m_rx  = '0;
            m_err = 1'b0;
        end else if (k == 0) begin
            if (tx_valid) begin
                k      = 1;
                m_word = tx_data;
                m_err  = 1'b0;
            end
        end else if (k == LAT) begin
            k = 0;
        end else begin
            k = k + 1;
            if (k == LAT) begin
                m_rx  = q_force0 ? '0 : m_word;
                m_err = CHECK_ON && (m_rx != m_word);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [WIDTH-1:0] t;
        logic             e_din;
        e_din = 1'b0;
        if (k >= 1 && k <= WIDTH) begin
            t     = m_word >> (k - 1);
            e_din = t[0];
        end
        chk("tx_ready", 32'(tx_ready), 32'(k == 0));
        chk("busy",     32'(busy),     32'(k != 0));
        chk("sr_shift", 32'(sr_shift), 32'(k >= 1 && k <= WIDTH + DEPTH));
        chk("sr_din",   32'(sr_din),   32'(e_din));
        chk("rx_valid", 32'(rx_valid), 32'(k == LAT));
        chk("rx_data",  32'(rx_data),  32'(m_rx));
        chk("err",      32'(err),      32'(m_err));
    end

    // Send one word from idle; returns the sr_din sequence, rx_valid count,
    // rx_data and err seen during the rx_valid cycle.
    task automatic run_word(input logic [WIDTH-1:0] w, output logic [11:0] seq,
                            output int nv, output logic [WIDTH-1:0] got, output logic e13);
        seq = '0; nv = 0; got = '0; e13 = 1'b0;
        tx_valid = 1'b1;
        tx_data  = w;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (sr_shift) seq = {seq[10:0], sr_din};
            if (rx_valid) begin
                nv++;
                got = rx_data;
                e13 = err;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0]      seq;
        int               nv;
        int               low_cnt;
        logic [WIDTH-1:0] got;
        logic             e13;

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; q_force0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_tx_ready", 32'(tx_ready), 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic
        run_word(8'hA5, seq, nv, got, e13);
        chk("basic_din_seq", 32'(seq), 32'b1010_0101_0000);
        chk("basic_valid_cnt", 32'(nv), 32'd1);
        chk("basic_rx", 32'(got), 32'hA5);
        chk("basic_err", 32'(e13), 32'h0);

        // Back-to-back with tx_valid held high
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk);
        #1 tx_data = 8'hC3;
        low_cnt = 0;
        got = '0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (!tx_ready) low_cnt++;
            if (c == LAT) got = rx_data;
        end
        chk("b2b_ready_low_cycles", 32'(low_cnt), 32'd13);
        chk("b2b_rx_first", 32'(got), 32'h3C);
        @(negedge clk);
        chk("b2b_ready_cycle14", 32'(tx_ready), 32'h1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        nv = 0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (rx_valid) begin
                nv++;
                got = rx_data;
            end
        end
        chk("b2b_valid_cnt", 32'(nv), 32'd1);
        chk("b2b_rx_second", 32'(got), 32'hC3);
        @(posedge clk);
        #1;

        // tx_data changes while busy
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 tx_data = 8'hFF;
        for (int c = 5; c <= LAT; c++) @(negedge clk);
        chk("busy_ignore_rx", 32'(rx_data), 32'h12);
        tx_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset in cycle 6
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_shift", 32'(sr_shift), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_ready", 32'(tx_ready), 32'h1);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_mid_rx_data", 32'(rx_data), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_word(8'h01, seq, nv, got, e13);
        chk("after_rst_rx", 32'(got), 32'h01);

        // Mismatch with sr_q stuck at 0
        q_force0 = 1'b1;
        run_word(8'hFF, seq, nv, got, e13);
        chk("mismatch_rx", 32'(got), 32'h00);
        chk("mismatch_err", 32'(e13), 32'(CHECK_ON));
        chk("mismatch_err_idle", 32'(err), 32'(CHECK_ON));
        q_force0 = 1'b0;

        // Alternating pattern; err must clear on accept
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("err_clear_on_accept", 32'(err), 32'h0);
        for (int c = 1; c <= LAT; c++) @(negedge clk);
        chk("alt55_rx", 32'(rx_data), 32'h55);
        chk("alt55_valid", 32'(rx_valid), 32'h1);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
